// File: rtl/pcie_io_tx_engine.sv
// Completion transmit stage: waits for the memory response to the request issued by the Rx
// engine, emits a 3DW Cpl/CplD TLP on the 64-bit AXI-S Tx port (none for posted writes), then pulses o_compl_done.
module pcie_io_tx_engine #(
  parameter int C_DATA_WIDTH           = 64,
  parameter int KEEP_WIDTH             = C_DATA_WIDTH / 8,
  parameter int CFG_PCIE_DMAADDR_WIDTH = 32
) (
  input  logic                              i_nrst,
  input  logic                              i_clk,
  input  logic                              i_s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0]           o_s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]             o_s_axis_tx_tkeep,
  output logic                              o_s_axis_tx_tlast,
  output logic                              o_s_axis_tx_tvalid,
  output logic [3:0]                        o_s_axis_tx_tuser,
  input  logic                              i_tx_ena,
  input  logic                              i_tx_completion,
  input  logic                              i_tx_with_data,
  output logic                              o_compl_done,
  input  logic [2:0]                        i_req_tc,
  input  logic                              i_req_td,
  input  logic                              i_req_ep,
  input  logic [1:0]                        i_req_attr,
  input  logic [9:0]                        i_req_len,
  input  logic [15:0]                       i_req_rid,
  input  logic [7:0]                        i_req_tag,
  input  logic [7:0]                        i_req_be,
  input  logic [CFG_PCIE_DMAADDR_WIDTH-1:0] i_req_addr,
  input  logic [15:0]                       i_completer_id,
  input  logic                              i_resp_mem_valid,
  input  logic [63:0]                       i_resp_mem_data
);

  typedef enum logic [2:0] {IDLE, WAIT_RESP, HDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic        cpld_q, posted_q;
  logic [31:0] dw_q;
  logic        dec_cpld, dec_cpl, dec_posted;
  logic [31:0] resp_dw;
  logic [11:0] byte_count;
  logic [1:0]  fmt;
  logic [9:0]  len_field;
  logic        unused_ok;

  assign unused_ok = ^{i_req_be[7:4], i_req_addr[CFG_PCIE_DMAADDR_WIDTH-1:7]};

  // Anything with ena=1 that is not a read or an IO write is handled as a posted write.
  assign dec_cpld   = i_tx_ena & i_tx_with_data & ~i_tx_completion;
  assign dec_cpl    = i_tx_ena & ~i_tx_with_data & i_tx_completion;
  assign dec_posted = ~(dec_cpld | dec_cpl);
  assign resp_dw    = i_req_addr[2] ? i_resp_mem_data[63:32] : i_resp_mem_data[31:0];

  always_comb begin
    byte_count = 12'd1;
    if (i_req_len != 10'd1) begin
      byte_count = {i_req_len, 2'b00};
    end else begin
      casez (i_req_be[3:0])
        4'b1??1:                    byte_count = 12'd4;
        4'b01?1, 4'b1?10:           byte_count = 12'd3;
        4'b0011, 4'b0110, 4'b1100:  byte_count = 12'd2;
        default:                    byte_count = 12'd1;
      endcase
    end
  end

  assign fmt       = cpld_q ? 2'b10 : 2'b00;
  assign len_field = cpld_q ? 10'd1 : 10'd0;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      cpld_q   <= 1'b0;
      posted_q <= 1'b0;
      dw_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && i_tx_ena) begin
        cpld_q   <= dec_cpld;
        posted_q <= dec_posted;
        if (i_resp_mem_valid) dw_q <= resp_dw;
      end
      if (state == WAIT_RESP && i_resp_mem_valid) dw_q <= resp_dw;
    end
  end

  always_comb begin
    state_nxt          = state;
    o_s_axis_tx_tdata  = '0;
    o_s_axis_tx_tkeep  = '0;
    o_s_axis_tx_tlast  = 1'b0;
    o_s_axis_tx_tvalid = 1'b0;
    o_s_axis_tx_tuser  = '0;
    o_compl_done       = 1'b0;
    unique case (state)
      IDLE: begin
        // A response arriving alongside the request is consumed directly, skipping WAIT_RESP.
        if (i_tx_ena) begin
          if (i_resp_mem_valid) state_nxt = dec_posted ? DONE : HDR;
          else                  state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (i_resp_mem_valid) state_nxt = posted_q ? DONE : HDR;
      end
      HDR: begin
        o_s_axis_tx_tvalid = 1'b1;
        o_s_axis_tx_tkeep  = '1;
        o_s_axis_tx_tdata  = {i_completer_id, 3'b000, 1'b0, byte_count,
                              1'b0, fmt, 5'b01010, 1'b0, i_req_tc, 4'b0000,
                              i_req_td, i_req_ep, i_req_attr, 2'b00, len_field};
        if (i_s_axis_tx_tready) state_nxt = DATA;
      end
      DATA: begin
        o_s_axis_tx_tvalid = 1'b1;
        o_s_axis_tx_tlast  = 1'b1;
        o_s_axis_tx_tkeep  = cpld_q ? '1 : {{(KEEP_WIDTH/2){1'b0}}, {(KEEP_WIDTH/2){1'b1}}};
        o_s_axis_tx_tdata  = {dw_q, i_req_rid, i_req_tag, 1'b0, i_req_addr[6:0]};
        if (i_s_axis_tx_tready) state_nxt = DONE;
      end
      DONE: begin
        o_compl_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_io_tx_engine.sv
// Bench for pcie_io_tx_engine: directed scenarios plus randomized requests checked against
// a TLP-level reference model built from the header field rules.
module tb_pcie_io_tx_engine;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tready = 1'b1;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid;
  logic [3:0]  tuser;
  logic        ena = 1'b0, completion = 1'b0, with_data = 1'b0;
  logic        done;
  logic [2:0]  tc = '0;
  logic        td = 1'b0, ep = 1'b0;
  logic [1:0]  attr = '0;
  logic [9:0]  len = 10'd1;
  logic [15:0] rid = '0, cid = '0;
  logic [7:0]  tag = '0, be = '0;
  logic [31:0] addr = '0;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_data = '0;

  int tests = 0;
  int fails = 0;
  logic [63:0] cap0, cap1;

  always #5 clk = ~clk;

  pcie_io_tx_engine #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .CFG_PCIE_DMAADDR_WIDTH(32)) dut (
    .i_nrst(nrst), .i_clk(clk), .i_s_axis_tx_tready(tready),
    .o_s_axis_tx_tdata(tdata), .o_s_axis_tx_tkeep(tkeep), .o_s_axis_tx_tlast(tlast),
    .o_s_axis_tx_tvalid(tvalid), .o_s_axis_tx_tuser(tuser),
    .i_tx_ena(ena), .i_tx_completion(completion), .i_tx_with_data(with_data),
    .o_compl_done(done), .i_req_tc(tc), .i_req_td(td), .i_req_ep(ep), .i_req_attr(attr),
    .i_req_len(len), .i_req_rid(rid), .i_req_tag(tag), .i_req_be(be), .i_req_addr(addr),
    .i_completer_id(cid), .i_resp_mem_valid(resp_valid), .i_resp_mem_data(resp_data)
  );

  task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag_s, obs, exp);
    end
  endtask

  // Byte count as the span from the first to the last enabled byte.
  function automatic logic [11:0] model_bc(input logic [3:0] b, input logic [9:0] l);
    int lo, hi;
    if (l != 10'd1) return 12'((int'(l) * 4) % 4096);
    if (b == 4'b0000) return 12'd1;
    lo = -1; hi = 0;
    for (int i = 0; i < 4; i++) if (b[i]) begin if (lo < 0) lo = i; hi = i; end
    return 12'(hi - lo + 1);
  endfunction

  task automatic randomize_req();
    tc   = 3'($urandom); td = 1'($urandom); ep = 1'($urandom); attr = 2'($urandom);
    len  = ($urandom % 4 == 0) ? 10'($urandom) : 10'd1;
    rid  = 16'($urandom); tag = 8'($urandom); be = 8'($urandom);
    addr = $urandom; cid = 16'($urandom);
  endtask

  // mode 0: tready=1; mode 1: random tready; mode 2: 5-cycle stall on each beat
  task automatic do_req(input logic [2:0] code, input int delay, input int mode,
                        input bit spurious, input logic [63:0] rdata);
    logic [63:0] eb [2];
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    logic [31:0] dw, w0, w1;
    bit          cpld, tlp, stall;
    int          nb, nd, first_v, done_at, after, idx;
    cpld = (code == 3'b101);
    tlp  = cpld || (code == 3'b011);
    dw   = addr[2] ? rdata[63:32] : rdata[31:0];
    w0   = ((cpld ? 32'd2 : 32'd0) << 29) | (32'd10 << 24) | (32'(tc) << 20) | (32'(td) << 15)
         | (32'(ep) << 14) | (32'(attr) << 12) | (cpld ? 32'd1 : 32'd0);
    w1   = (32'(cid) << 16) | 32'(model_bc(be[3:0], len));
    eb[0] = {w1, w0};
    eb[1] = {dw, (32'(rid) << 16) | (32'(tag) << 8) | 32'(addr[6:0])};
    cap0 = '0; cap1 = '0;
    {with_data, completion, ena} = code;
    nb = 0; nd = 0; first_v = -1; done_at = -1; after = 0; stall = 1'b0;
    pd = '0; pk = '0; pl = 1'b0;
    for (int k = 0; k < 300 && after < 3; k++) begin
      idx = k - (delay + 1);
      case (mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom % 3) != 0;
        default: tready = !((idx >= 0 && idx < 5) || (idx >= 6 && idx < 11));
      endcase
      resp_valid = (k == delay) || (spurious && k > delay && ($urandom % 3 == 0));
      resp_data  = (k == delay) ? rdata : {$urandom, $urandom};
      #1;
      if (stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, pd);
        chk("hold_keep", tkeep, pk);
        chk("hold_last", tlast, pl);
      end
      if (tvalid && first_v < 0) first_v = k;
      if (tvalid && tready) begin
        if (nb < 2) begin
          chk("beat_data", tdata, eb[nb]);
          chk("beat_keep", tkeep, (nb == 1 && !cpld) ? 8'h0F : 8'hFF);
          chk("beat_last", tlast, nb == 1);
          if (nb == 0) cap0 = tdata; else cap1 = tdata;
        end
        nb++;
      end
      if (done) begin
        nd++;
        if (done_at < 0) done_at = k;
        {with_data, completion, ena} = 3'b000;
      end
      if (nd > 0) after++;
      stall = tvalid && !tready;
      pd = tdata; pk = tkeep; pl = tlast;
      @(posedge clk); #1;
    end
    resp_valid = 1'b0;
    {with_data, completion, ena} = 3'b000;
    chk("done_count", nd, 1);
    chk("beat_count", nb, tlp ? 2 : 0);
    chk("first_valid", first_v, tlp ? delay + 1 : -1);
    if (mode == 0) chk("done_latency", done_at, tlp ? delay + 3 : delay + 1);
    if (mode == 2) chk("done_latency_bp", done_at, delay + 13);
    chk("tuser", tuser, 0);
  endtask

  initial begin
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // MemRd32 read completion with known header
    tc = '0; td = 0; ep = 0; attr = '0; len = 10'd1; be = 8'h0F;
    addr = 32'h0800_0004; tag = 8'h12; rid = 16'h0100; cid = 16'h0200;
    do_req(3'b101, 2, 0, 0, 64'hAABBCCDD_11223344);
    chk("t1_beat0", cap0, 64'h02000004_4A000001);
    chk("t1_beat1", cap1, 64'hAABBCCDD_01001204);

    // Posted write, response 3 cycles later
    randomize_req();
    do_req(3'b001, 3, 0, 0, 64'h1);

    // IO write completion
    randomize_req();
    len = 10'd1; be = 8'h06; addr = 32'h0000_0011;
    do_req(3'b011, 1, 0, 0, 64'h0);
    chk("t3_bc", cap0[43:32], 12'd2);
    chk("t3_fmt", cap0[30:29], 2'b00);
    chk("t3_len", cap0[9:0], 10'd0);
    chk("t3_laddr", cap1[6:0], 7'h11);

    // Backpressure on both beats
    randomize_req();
    do_req(3'b101, 1, 2, 1, {$urandom, $urandom});

    // Same-cycle response
    randomize_req();
    do_req(3'b101, 0, 0, 0, {$urandom, $urandom});

    // Reset during a stalled DATA beat
    randomize_req();
    {with_data, completion, ena} = 3'b101;
    resp_valid = 1'b1; resp_data = {$urandom, $urandom}; tready = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(posedge clk); #1;
    tready = 1'b0;
    #1;
    chk("pre_rst_in_data", {tvalid, tlast}, 2'b11);
    nrst = 1'b0;
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_tdata", tdata, 0);
    {with_data, completion, ena} = 3'b000;
    tready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_done_hold", done, 0);
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {tvalid, done}, 2'b00);
    randomize_req();
    do_req(3'b101, 1, 0, 0, {$urandom, $urandom});

    // Randomized requests, including odd decode values and stray response strobes
    for (int n = 0; n < 40; n++) begin
      randomize_req();
      do_req({2'($urandom), 1'b1}, int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
             1'($urandom), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
